// File: rtl/cla_pipe_adder.sv
// Two-stage carry-lookahead adder/subtractor: stage 1 forms bit and group propagate/generate,
// stage 2 resolves group and bit carries and registers the result; elastic valid/ready, 2-beat capacity.
module cla_pipe_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int NG = WIDTH / 4;

    logic                 s1_valid_q;
    logic [WIDTH-1:0]     p_q, p_d;
    logic [NG-1:0][2:0]   g_q, g_d;
    logic [NG-1:0]        gp_q, gp_d;
    logic [NG-1:0]        gg_q, gg_d;
    logic                 c0_q, c0_d;

    logic                 out_valid_q;
    logic [WIDTH-1:0]     sum_q, sum_d;
    logic                 cout_q, cout_d;
    logic                 ovf_q, ovf_d;

    logic                 s1_adv, s2_adv;
    logic [WIDTH-1:0]     bb;
    logic [3:0]           g4, p4;
    logic [NG:0]          cg;
    logic [WIDTH-1:0]     c;
    logic                 acc, prod;

    assign s2_adv   = !out_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;

    always_comb begin
        bb   = sub ? ~b : b;
        c0_d = sub | cin;
        p_d  = a ^ bb;
        g4   = '0;
        p4   = '0;
        g_d  = '0;
        gp_d = '0;
        gg_d = '0;
        for (int k = 0; k < NG; k++) begin
            g4      = a[4*k +: 4] & bb[4*k +: 4];
            p4      = p_d[4*k +: 4];
            g_d[k]  = g4[2:0];
            gp_d[k] = &p4;
            gg_d[k] = g4[3] | (p4[3] & g4[2]) | (p4[3] & p4[2] & g4[1])
                    | (p4[3] & p4[2] & p4[1] & g4[0]);
        end
    end

    // Each carry is an independent sum of products; the loops unroll into flat lookahead terms.
    always_comb begin
        cg    = '0;
        c     = '0;
        acc   = 1'b0;
        prod  = 1'b0;
        cg[0] = c0_q;
        for (int k = 0; k < NG; k++) begin
            acc  = gg_q[k];
            prod = gp_q[k];
            for (int j = k - 1; j >= 0; j--) begin
                acc  = acc | (prod & gg_q[j]);
                prod = prod & gp_q[j];
            end
            cg[k+1] = acc | (prod & c0_q);
        end
        for (int k = 0; k < NG; k++) begin
            c[4*k] = cg[k];
            for (int i = 1; i < 4; i++) begin
                acc  = g_q[k][i-1];
                prod = p_q[4*k+i-1];
                for (int j = i - 2; j >= 0; j--) begin
                    acc  = acc | (prod & g_q[k][j]);
                    prod = prod & p_q[4*k+j];
                end
                c[4*k+i] = acc | (prod & cg[k]);
            end
        end
        sum_d  = p_q ^ c;
        cout_d = cg[NG];
        ovf_d  = c[WIDTH-1] ^ cg[NG];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            p_q        <= '0;
            g_q        <= '0;
            gp_q       <= '0;
            gg_q       <= '0;
            c0_q       <= 1'b0;
        end else if (s1_adv) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                p_q  <= p_d;
                g_q  <= g_d;
                gp_q <= gp_d;
                gg_q <= gg_d;
                c0_q <= c0_d;
            end
        end
    end

    // Result fields only load with a real beat so they hold their last value while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (s2_adv) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                sum_q  <= sum_d;
                cout_q <= cout_d;
                ovf_q  <= ovf_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder: arithmetic reference model with an in-order expectation queue,
// directed literal vectors, backpressure, mid-stream reset, full-throughput and random phases.
module tb_cla_pipe_adder;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready;
    logic [W-1:0] a, b;
    logic         cin, sub;
    logic         out_valid, out_ready;
    logic [W-1:0] sum;
    logic         cout, ovf;

    always #5 clk = ~clk;

    cla_pipe_adder #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    typedef struct {
        logic [W+1:0] res;
        int           tag;
    } beat_t;

    beat_t        q[$];
    logic [W+1:0] last_res;
    int           ncyc = 0;
    bit           chk_en = 1'b0;
    int           pass_cnt = 0;
    int           tot_cnt = 0;

    // Returns {ovf, cout, sum} from plain integer arithmetic.
    function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic mcin, input logic msub);
        logic [W-1:0] bb;
        logic [W:0]   full;
        logic         o;
        bb   = msub ? ~mb : mb;
        full = {1'b0, ma} + {1'b0, bb} + {{W{1'b0}}, (msub ? 1'b1 : mcin)};
        o    = (ma[W-1] == bb[W-1]) && (full[W-1] != ma[W-1]);
        return {o, full[W], full[W-1:0]};
    endfunction

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    // Per-cycle compare against the model; transfers are decided from the model's own view.
    always @(negedge clk) begin
        bit exp_ov, exp_ir;
        ncyc++;
        if (chk_en) begin
            exp_ov = (q.size() > 0) && (ncyc - q[0].tag >= 2);
            exp_ir = !(q.size() == 2 && !out_ready);
            chk("out_valid", {79'd0, out_valid}, {79'd0, exp_ov});
            chk("in_ready", {79'd0, in_ready}, {79'd0, exp_ir});
            if (exp_ov) chk("result", {ovf, cout, sum}, q[0].res);
            else        chk("idle_hold", {ovf, cout, sum}, last_res);
            if (exp_ov && out_ready) begin
                last_res = q[0].res;
                void'(q.pop_front());
            end
            if (in_valid && exp_ir) q.push_back('{res: model(a, b, cin, sub), tag: ncyc});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_dir(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tcin,
                            input logic tsub, input logic [W+1:0] lit, input string nm);
        tick();
        a = ta; b = tb_; cin = tcin; sub = tsub; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk({nm, "_dut"}, {61'd0, out_valid, ovf, cout, sum}, {61'd0, 1'b1, lit});
        chk({nm, "_model"}, {62'd0, model(ta, tb_, tcin, tsub)}, {62'd0, lit});
    endtask

    task automatic drain();
        int n;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (q.size() > 0 && n < 50) begin
            tick();
            n++;
        end
        chk("drain_empty", {48'd0, q.size()}, 80'd0);
    endtask

    task automatic rand_beat();
        a   = ($urandom_range(0, 7) == 0) ? {W{1'b1}} : W'($urandom);
        b   = ($urandom_range(0, 7) == 0) ? {W{1'b0}} : W'($urandom);
        cin = 1'($urandom);
        sub = 1'($urandom);
    endtask

    initial begin
        int  sent, n, acc_n, out_n;
        bit  acc, saw_low;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        last_res = '0;
        repeat (3) @(negedge clk);
        chk("reset_state", {76'd0, in_ready, out_valid, cout, ovf}, {76'd0, 4'b1000});
        chk("reset_sum", {64'd0, sum}, 80'd0);
        rst_n = 1'b1;
        tick();
        chk_en = 1'b1;

        send_dir(16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 16'h0000}, "add_wrap");
        send_dir(16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 16'h8000}, "add_ovf");
        send_dir(16'h0005, 16'h0007, 1'b1, 1'b1, {1'b0, 1'b0, 16'hFFFE}, "sub_neg");
        send_dir(16'h8000, 16'h0001, 1'b0, 1'b1, {1'b1, 1'b1, 16'h7FFF}, "sub_ovf");
        send_dir(16'hAAAA, 16'h5555, 1'b1, 1'b0, {1'b0, 1'b1, 16'h0000}, "prop_cin1");
        send_dir(16'hAAAA, 16'h5555, 1'b0, 1'b0, {1'b0, 1'b0, 16'hFFFF}, "prop_cin0");
        drain();

        // Backpressure: 8 beats streamed, consumer stalls in cycles 3..6.
        sent = 0; saw_low = 1'b0; n = 0;
        tick();
        rand_beat(); in_valid = 1'b1;
        while (sent < 8 && n < 100) begin
            n++;
            out_ready = !(n >= 3 && n <= 6);
            @(negedge clk);
            if (!in_ready) saw_low = 1'b1;
            acc = in_valid && in_ready;
            if (acc) sent++;
            tick();
            if (acc) begin
                if (sent < 8) rand_beat();
                else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        chk("bp_sent", {48'd0, sent}, 80'd8);
        chk("bp_in_ready_low", {79'd0, saw_low}, {79'd0, 1'b1});
        drain();

        // Mid-stream reset with two beats in flight.
        out_ready = 1'b0; rand_beat(); in_valid = 1'b1; n = 0;
        do begin
            @(negedge clk);
            acc = in_valid && in_ready;
            tick();
            if (acc) rand_beat();
            n++;
        end while (in_ready && n < 20);
        chk("rst_two_in_flight", {78'd0, q.size() == 2, out_valid}, {78'd0, 2'b11});
        #2;
        chk_en = 1'b0; in_valid = 1'b0; rst_n = 1'b0;
        #1;
        chk("rst_async_flags", {77'd0, out_valid, cout, ovf}, 80'd0);
        chk("rst_async_sum", {64'd0, sum}, 80'd0);
        q.delete();
        last_res = '0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rst_in_ready", {79'd0, in_ready}, {79'd0, 1'b1});
        chk_en = 1'b1; out_ready = 1'b1;
        repeat (6) tick();

        // Full throughput: 64 back-to-back beats, consumer always ready.
        acc_n = 0; out_n = 0;
        rand_beat(); in_valid = 1'b1;
        for (int i = 1; i <= 66; i++) begin
            @(negedge clk);
            if (in_valid && in_ready) acc_n++;
            if (out_valid && out_ready) out_n++;
            tick();
            if (i < 64) rand_beat();
            else in_valid = 1'b0;
        end
        chk("thr_accepted", {48'd0, acc_n}, 80'd64);
        chk("thr_delivered", {48'd0, out_n}, 80'd64);
        drain();

        // Random valid/ready for 1000 beats.
        sent = 0; n = 0;
        in_valid = 1'b0;
        while (sent < 1000 && n < 20000) begin
            n++;
            @(negedge clk);
            acc = in_valid && in_ready;
            if (acc) sent++;
            tick();
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid || acc) begin
                in_valid = (sent < 1000) && ($urandom_range(0, 2) != 0);
                rand_beat();
            end
        end
        in_valid = 1'b0;
        chk("rand_sent", {48'd0, sent}, 80'd1000);
        drain();

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
